// File: rtl/dds_form_wave_pkg.sv
// Shared constants, form codes and the note-to-increment table builder for dds_form_wave.
// Optional feature macro used by the top: FORM_WAVE_PWM_EN.
package dds_form_wave_pkg;

    localparam int PHASE_W  = 32;
    localparam int NOTE_W   = 8;
    localparam int MIDI_MAX = 127;
    localparam int OCT_MAX  = 10;
    localparam int SEMIS    = 12;

    localparam logic [2:0] FORM_SAW    = 3'd0;
    localparam logic [2:0] FORM_REVSAW = 3'd1;
    localparam logic [2:0] FORM_TRIAN  = 3'd2;
    localparam logic [2:0] FORM_MEAN   = 3'd3;
    localparam logic [2:0] FORM_PULSE  = 3'd4;

    // Duty used by the pulse form when programmable duty is not built in (25%).
    localparam logic [6:0] FIXED_DUTY = 7'd32;

    typedef logic [SEMIS-1:0][PHASE_W-1:0] inc_table_t;

    typedef struct packed {
        logic [3:0] octave;
        logic [3:0] semi;
    } note_split_t;

    // Increments for the top octave (MIDI 120..131); lower octaves are right shifts of these.
    function automatic inc_table_t build_inc_table(input longint clk_hz);
        inc_table_t tab;
        real        freq;
        for (int k = 0; k < SEMIS; k++) begin
            freq   = 440.0 * (2.0 ** ((51.0 + real'(k)) / 12.0));
            tab[k] = $rtoi(freq * 4294967296.0 / real'(clk_hz) + 0.5);
        end
        return tab;
    endfunction

    // Divide a 0..127 note by 12 with a comparator chain instead of a divider.
    function automatic note_split_t split_note(input logic [6:0] n);
        note_split_t s;
        s.octave = 4'd0;
        s.semi   = n[3:0];
        for (int i = 1; i <= OCT_MAX; i++) begin
            if (n >= 7'(SEMIS * i)) begin
                s.octave = 4'(i);
                s.semi   = 4'(n - 7'(SEMIS * i));
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/dds_form_wave_phase_acc.sv
// 32-bit phase accumulator: phase advances by the registered increment every clock, wrapping mod 2^32.
module dds_phase_acc
    import dds_form_wave_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] adder,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_d;
    logic [PHASE_W-1:0] phase_q;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        phase_d = phase_q + adder;
    end

    // NOTE: sequential state uses <= so all flops sample their pre-edge inputs together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/dds_form_wave.sv
// Note-driven DDS oscillator: MIDI note -> phase increment -> accumulator -> five-way wave shaper.
// Define FORM_WAVE_PWM_EN to make the pulse duty follow pulse_width; otherwise the pulse is a fixed 25%.
module dds_form_wave
    import dds_form_wave_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NOTE_W-1:0]  NOTE,
    input  logic [2:0]         form,
    input  logic [6:0]         pulse_width,
    output logic [PHASE_W-1:0] ADDER,
    output logic [PHASE_W-1:0] DDS,
    output logic [PHASE_W-1:0] DDSout
);

    localparam inc_table_t INC_TABLE = build_inc_table(longint'(CLK_HZ));

    logic [6:0]         note_clamped;
    note_split_t        note_split;
    logic [PHASE_W-1:0] adder_d;
    logic [PHASE_W-1:0] adder_q;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] tri_ramp;
    logic [6:0]         duty;
    logic [PHASE_W-1:0] dds_out_d;
    logic [PHASE_W-1:0] dds_out_q;

    always_comb begin
        note_clamped = (NOTE > NOTE_W'(MIDI_MAX)) ? 7'(MIDI_MAX) : NOTE[6:0];
        note_split   = split_note(note_clamped);
        adder_d      = INC_TABLE[note_split.semi] >> (4'(OCT_MAX) - note_split.octave);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            adder_q <= '0;
        end else begin
            adder_q <= adder_d;
        end
    end

    dds_phase_acc u_phase_acc (
        .clk   (CLK),
        .rst   (RESET),
        .adder (adder_q),
        .phase (phase)
    );

`ifdef FORM_WAVE_PWM_EN
    assign duty = pulse_width;
`else
    logic unused_pulse_width;
    assign duty               = FIXED_DUTY;
    assign unused_pulse_width = ^pulse_width;
`endif

    always_comb begin
        tri_ramp  = {phase[PHASE_W-2:0], 1'b0};
        dds_out_d = '0;
        case (form)
            FORM_SAW:    dds_out_d = phase;
            FORM_REVSAW: dds_out_d = ~phase;
            FORM_TRIAN:  dds_out_d = phase[PHASE_W-1] ? ~tri_ramp : tri_ramp;
            FORM_MEAN:   dds_out_d = phase[PHASE_W-1] ? '0 : '1;
            FORM_PULSE:  dds_out_d = (phase[PHASE_W-1 -: 7] < duty) ? '1 : '0;
            default:     dds_out_d = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dds_out_q <= '0;
        end else begin
            dds_out_q <= dds_out_d;
        end
    end

    assign ADDER  = adder_q;
    assign DDS    = phase;
    assign DDSout = dds_out_q;

endmodule

// File: tb/tb_dds_form_wave.sv
// Self-checking bench for dds_form_wave: note table vectors, waveform sweeps, duty, wrap and reset.
module tb_dds_form_wave;

    localparam int CLK_HZ = 50_000_000;
`ifdef FORM_WAVE_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  note;
    logic [2:0]  form;
    logic [6:0]  pw;
    logic [31:0] adder;
    logic [31:0] dds;
    logic [31:0] ddsout;

    always #10 clk = ~clk;

    dds_form_wave #(.CLK_HZ(CLK_HZ)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .NOTE        (note),
        .form        (form),
        .pulse_width (pw),
        .ADDER       (adder),
        .DDS         (dds),
        .DDSout      (ddsout)
    );

    typedef struct packed {
        logic [31:0] adder;
        logic [31:0] dds;
        logic [31:0] out;
    } exp_t;

    typedef struct {
        logic [7:0]  note;
        logic [31:0] exp_adder;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] m_adder;
    logic [31:0] m_dds;
    logic [31:0] m_out;
    logic [31:0] ref_tab[12];
    vec_t        vecs[8];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_adder(input logic [7:0] n_in);
        int n;
        n = (n_in > 8'd127) ? 127 : int'(n_in);
        return ref_tab[n % 12] >> (10 - n / 12);
    endfunction

    function automatic logic [31:0] ref_shape(input logic [31:0] p, input logic [2:0] f,
                                              input logic [6:0] w);
        logic [31:0] t;
        logic [6:0]  d;
        t = {p[30:0], 1'b0};
        d = PWM ? w : 7'd32;
        case (f)
            3'd0:    return p;
            3'd1:    return ~p;
            3'd2:    return p[31] ? ~t : t;
            3'd3:    return p[31] ? 32'h0 : 32'hFFFF_FFFF;
            3'd4:    return (p[31:25] < d) ? 32'hFFFF_FFFF : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // Predict the next register values from the current inputs, then compare after the edge.
    task automatic step();
        exp_t e;
        e.adder = ref_adder(note);
        e.dds   = m_dds + m_adder;
        e.out   = ref_shape(m_dds, form, pw);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e       = sb_q.pop_front();
        m_adder = e.adder;
        m_dds   = e.dds;
        m_out   = e.out;
        check("adder", adder, e.adder);
        check("dds", dds, e.dds);
        check("ddsout", ddsout, e.out);
    endtask

    task automatic model_reset();
        m_adder = '0;
        m_dds   = '0;
        m_out   = '0;
        sb_q.delete();
    endtask

    initial begin
        int   highs;
        int   wraps;
        int   period;
        real  want;
        logic [31:0] prev;

        for (int k = 0; k < 12; k++)
            ref_tab[k] = $rtoi(440.0 * (2.0 ** ((51.0 + real'(k)) / 12.0)) * 4294967296.0
                               / real'(CLK_HZ) + 0.5);

        vecs[0] = '{8'd69,  32'd37795};
        vecs[1] = '{8'd0,   32'd702};
        vecs[2] = '{8'd127, 32'd1077509};
        vecs[3] = '{8'd200, 32'd1077509};
        vecs[4] = '{8'd255, 32'd1077509};
        vecs[5] = '{8'd120, 32'd719151};
        vecs[6] = '{8'd117, 32'd604731};
        vecs[7] = '{8'd60,  32'd22473};

        rst  = 1'b1;
        note = 8'd69;
        form = 3'd0;
        pw   = 7'd40;
        model_reset();
        #5;
        check("rst_adder", adder, 32'h0);
        check("rst_dds", dds, 32'h0);
        check("rst_ddsout", ddsout, 32'h0);
        #95 rst = 1'b0;

        // First edge after release: increment appears, phase still at 0.
        step();
        check("note69_adder", adder, 32'd37795);
        check("note69_dds0", dds, 32'h0);
        step();
        check("note69_dds1", dds, 32'd37795);

        foreach (vecs[i]) begin
            note = vecs[i].note;
            step();
            check("vec_adder", adder, vecs[i].exp_adder);
            step();
        end

        // Approach p = 0x40000000 with the fastest note, then sweep every form code across it.
        note = 8'd127;
        for (int i = 0; i < 1200 && m_dds < 32'h3F80_0000; i++) step();
        check("reach_q1", 32'(dds >= 32'h3F80_0000), 32'd1);
        for (int i = 0; i < 16; i++) begin
            form = 3'(i % 8);
            step();
        end

        // Triangle across its peak near p = 0x80000000.
        form = 3'd2;
        for (int i = 0; i < 1200 && m_dds < 32'h7F80_0000; i++) step();
        check("reach_half", 32'(dds >= 32'h7F80_0000), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            check("tri_max", 32'(ddsout <= 32'hFFFF_FFFE), 32'd1);
        end

        // One full period of the pulse: high fraction and at least one phase wrap.
        form   = 3'd4;
        step();
        period = 3986;
        highs  = 0;
        wraps  = 0;
        for (int i = 0; i < period; i++) begin
            prev = m_dds;
            step();
            if (ddsout == 32'hFFFF_FFFF) highs++;
            if (m_dds < prev) wraps++;
        end
        want = PWM ? real'(period) * real'(pw) / 128.0 : real'(period) / 4.0;
        check("duty", 32'((real'(highs) >= want - 2.0) && (real'(highs) <= want + 2.0)), 32'd1);
        check("wrapped", 32'(wraps >= 1), 32'd1);

        // Reset asserted mid-cycle clears everything immediately.
        form = 3'd0;
        note = 8'd69;
        step();
        #5 rst = 1'b1;
        #1;
        check("midrst_adder", adder, 32'h0);
        check("midrst_dds", dds, 32'h0);
        check("midrst_ddsout", ddsout, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("held_rst_dds", dds, 32'h0);
        #3 rst = 1'b0;
        step();
        check("restart_dds0", dds, 32'h0);
        step();
        check("restart_dds1", dds, 32'd37795);

        // Unused form codes produce silence.
        for (int f = 5; f < 8; f++) begin
            form = 3'(f);
            for (int i = 0; i < 4; i++) begin
                step();
                check("unused_form", ddsout, 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
